// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job dispatcher and its FIFO.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_job_t;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] y;
        logic                 err;
    } gcd_result_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Synchronous job FIFO: first-word-fall-through read port, full/empty flags,
// no write-through when full, simultaneous push/pop keeps occupancy unchanged.
module gcd_job_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// GCD job dispatcher: queues operand pairs, issues them one at a time to the
// GCD core with a single-cycle start, and returns results in order over a
// valid/ready port. Optional watchdog: define GCD_DISPATCH_TIMEOUT_EN.
module gcd_job_dispatcher
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic             gcd_error,
    input  logic [WIDTH-1:0] gcd_y,
    output logic             busy,
    output logic [15:0]      job_cnt
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               core_resp;
    logic               timeout_hit;
    logic               job_end;
    logic               handoff;

    assign in_ready  = !fifo_full;
    // A new job only leaves the FIFO once the result slot is free, so the
    // core never holds more than one job and results cannot be overwritten.
    assign pop       = (state == ST_IDLE) && !fifo_empty && !out_valid;
    assign core_resp = (state == ST_WAIT) && (gcd_done || gcd_error);
    assign job_end   = core_resp || timeout_hit;
    assign handoff   = out_valid && out_ready;
    assign gcd_start = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE) || !fifo_empty || out_valid;

    gcd_job_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (in_valid && in_ready),
        .wr_data ({in_a, in_b}),
        .full    (fifo_full),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    // Watchdog: cleared on the edge entering WAIT, counts each WAIT cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; a real response that cycle wins.
    assign timeout_hit = (state == ST_WAIT) && !core_resp &&
                         (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Dispatch FSM: IDLE pops, ISSUE pulses start, WAIT holds for the core.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (pop) state <= ST_ISSUE;
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT:  if (job_end) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Operands to the core change only on a pop, so they stay stable
    // throughout ISSUE and WAIT.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gcd_a <= '0;
            gcd_b <= '0;
        end else if (pop) begin
            gcd_a <= head[2*WIDTH-1:WIDTH];
            gcd_b <= head[WIDTH-1:0];
        end
    end

    // Result slot: filled when the job ends, held until the consumer takes it.
    // Error wins when done and error arrive together; Y is still captured.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_err   <= 1'b0;
        end else if (job_end) begin
            out_valid <= 1'b1;
            out_y     <= core_resp ? gcd_y : '0;
            out_err   <= core_resp ? gcd_error : 1'b1;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    // Count of results handed off; wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            job_cnt <= '0;
        end else if (handoff) begin
            job_cnt <= job_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Self-checking bench for gcd_job_dispatcher: a GCD core model answers
// start pulses, and a scoreboard holds expected results in push order.
module tb_gcd_job_dispatcher;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1023;
`endif

    typedef struct {
        logic [7:0] y;
        logic       err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        out_err;
    logic        gcd_start;
    logic [7:0]  gcd_a;
    logic [7:0]  gcd_b;
    logic        gcd_done;
    logic        gcd_error;
    logic [7:0]  gcd_y;
    logic        busy;
    logic [15:0] job_cnt;

    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [7:0]  m_y = '0;
    logic        stray_done = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    int          fixed_lat = -1;

    exp_t        exp_q[$];
    logic [15:0] iss_q[$];
    logic [15:0] n_hand = '0;

    assign gcd_done  = m_done | stray_done;
    assign gcd_error = m_err;
    assign gcd_y     = m_y;

    gcd_job_dispatcher #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_err   (out_err),
        .gcd_start (gcd_start),
        .gcd_a     (gcd_a),
        .gcd_b     (gcd_b),
        .gcd_done  (gcd_done),
        .gcd_error (gcd_error),
        .gcd_y     (gcd_y),
        .busy      (busy),
        .job_cnt   (job_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Expected result of a job: FE/FE never answered (watchdog), FF/FF gets
    // done+error with Y=2A, a zero operand gets error with Y=a^b.
    function automatic exp_t ref_result(input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        if (a == 8'hFE && b == 8'hFE) begin
            r.y = 8'h00; r.err = 1'b1;
        end else if (a == 8'hFF && b == 8'hFF) begin
            r.y = 8'h2A; r.err = 1'b1;
        end else if (a == 8'h00 || b == 8'h00) begin
            r.y = a ^ b; r.err = 1'b1;
        end else begin
            r.y = ref_gcd(a, b); r.err = 1'b0;
        end
        return r;
    endfunction

    // Consumer readiness: held low, held high, or randomly toggled.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor, scoreboard and GCD core model, all sampled on the falling edge.
    initial begin
        bit         pending = 1'b0;
        int         cd = 0;
        logic [7:0] cur_a = '0;
        logic [7:0] cur_b = '0;
        exp_t       e;
        logic [15:0] j;
        forever begin
            @(negedge CLK);
            m_done = 1'b0;
            m_err  = 1'b0;
            m_y    = 8'($urandom);
            if (!RST_N) begin
                exp_q.delete();
                iss_q.delete();
                pending = 1'b0;
                n_hand  = '0;
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_result(in_a, in_b));
                    iss_q.push_back({in_a, in_b});
                end
                if (out_valid && out_ready) begin
                    chk("result_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_y", 32'(out_y), 32'(e.y));
                        chk("out_err", 32'(out_err), 32'(e.err));
                    end
                    chk("job_cnt", 32'(job_cnt), 32'(n_hand));
                    n_hand = n_hand + 16'd1;
                end
                if (gcd_start) begin
                    chk("start_single", 32'(pending), 0);
                    chk("start_expected", 32'(iss_q.size() > 0), 1);
                    if (iss_q.size() > 0) begin
                        j = iss_q.pop_front();
                        chk("gcd_a", 32'(gcd_a), 32'(j[15:8]));
                        chk("gcd_b", 32'(gcd_b), 32'(j[7:0]));
                    end
                    cur_a   = gcd_a;
                    cur_b   = gcd_b;
                    pending = !(gcd_a == 8'hFE && gcd_b == 8'hFE);
                    cd      = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
                end else if (pending) begin
                    if (cd == 0) begin
                        pending = 1'b0;
                        chk("a_stable", 32'(gcd_a), 32'(cur_a));
                        chk("b_stable", 32'(gcd_b), 32'(cur_b));
                        if (cur_a == 8'hFF && cur_b == 8'hFF) begin
                            m_done = 1'b1; m_err = 1'b1; m_y = 8'h2A;
                        end else if (cur_a == 8'h00 || cur_b == 8'h00) begin
                            m_err = 1'b1; m_y = cur_a ^ cur_b;
                        end else begin
                            m_done = 1'b1; m_y = ref_gcd(cur_a, cur_b);
                        end
                    end else begin
                        cd--;
                    end
                end
            end
        end
    end

    // Offer one job and hold it until accepted; returns just after the push edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, input int budget);
        bit ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_accepted", 32'(ok), 1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_done", 32'(n < budget), 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_y"}, 32'(out_y), 0);
        chk({tag, "_out_err"}, 32'(out_err), 0);
        chk({tag, "_gcd_start"}, 32'(gcd_start), 0);
        chk({tag, "_gcd_a"}, 32'(gcd_a), 0);
        chk({tag, "_gcd_b"}, 32'(gcd_b), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_job_cnt"}, 32'(job_cnt), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time exhausted");
        $fatal(1, "bench watchdog");
    end

    // Main stimulus sequence.
    initial begin
        int n;
        int k;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        chk_reset_state("rst");

        // Basic job with latency checks.
        ready_mode = 1;
        fixed_lat  = 5;
        @(posedge CLK);
        #1;
        push(8'd12, 8'd18, 20);
        @(negedge CLK);
        chk("start_lat1", 32'(gcd_start), 0);
        @(negedge CLK);
        chk("start_lat2", 32'(gcd_start), 1);
        @(posedge CLK);
        #1;
        wait_drain(100);
        chk("job_cnt_one", 32'(job_cnt), 1);

        // Error response, then simultaneous done+error.
        push(8'd0, 8'd5, 20);
        wait_drain(100);
        push(8'hFF, 8'hFF, 20);
        wait_drain(100);

        // Backpressure: one result held, four jobs queued, FIFO full.
        ready_mode = 0;
        fixed_lat  = 3;
        @(posedge CLK);
        #1;
        push(8'd8, 8'd12, 20);
        push(8'd9, 8'd6, 20);
        push(8'd7, 8'd7, 20);
        push(8'd20, 8'd15, 20);
        push(8'd27, 8'd18, 20);
        @(negedge CLK);
        chk("full_in_ready", 32'(in_ready), 0);
        repeat (15) @(negedge CLK);
        chk("held_in_ready", 32'(in_ready), 0);
        chk("held_out_valid", 32'(out_valid), 1);
        chk("held_out_y", 32'(out_y), 4);
        @(posedge CLK);
        #1;
        ready_mode = 1;
        push(8'd35, 8'd21, 100);
        wait_drain(300);

        // Randomized jobs with random gaps, latencies and consumer stalls.
        ready_mode = 2;
        fixed_lat  = -1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
            ra = 8'($urandom_range(1, 200));
            rb = 8'($urandom_range(1, 200));
            if ($urandom_range(0, 9) == 0) ra = 8'd0;
            if ($urandom_range(0, 9) == 0) rb = 8'd0;
            push(ra, rb, 200);
        end
        ready_mode = 1;
        wait_drain(2000);

        // Reset during WAIT with two jobs queued, then a stray done.
        fixed_lat = 20;
        push(8'd10, 8'd4, 20);
        push(8'd15, 8'd25, 20);
        push(8'd14, 8'd21, 20);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        chk_reset_state("midrst");
        stray_done = 1'b1;
        @(posedge CLK);
        #1;
        stray_done = 1'b0;
        repeat (3) @(negedge CLK);
        chk("stray_out_valid", 32'(out_valid), 0);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_start", 32'(gcd_start), 0);
        @(posedge CLK);
        #1;
        fixed_lat = -1;
        push(8'd44, 8'd66, 20);
        wait_drain(100);
        chk("post_rst_job_cnt", 32'(job_cnt), 1);

`ifdef GCD_DISPATCH_TIMEOUT_EN
        // Silent core: watchdog must produce an error result after TIMEOUT cycles.
        push(8'hFE, 8'hFE, 20);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!gcd_start && n < 20);
        chk("to_start_seen", 32'(gcd_start), 1);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!out_valid && k < 100);
        chk("to_latency", 32'(k), 32'(TIMEOUT + 1));
        chk("to_out_err", 32'(out_err), 1);
        chk("to_out_y", 32'(out_y), 0);
        @(posedge CLK);
        #1;
        push(8'd3, 8'd9, 20);
        wait_drain(100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
